// File: rtl/video_pkg.sv
// Shared video constants (640x480@60 timing) and the width helper used by the
// framebuffer video generator.
package video_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Bits needed to hold the value n itself, so an address equal to a memory
  // size stays expressible and can be rejected rather than aliased.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'd1 << w) <= 64'(n))) w++;
    return w;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Free-running raster counters with unregistered active/sync/vblank decode.
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = clog2(H_TOTAL),
  localparam int unsigned VW      = clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          vblank_start
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    active       = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    hsync        = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vsync        = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    vblank_start = (hcnt == '0) && (vcnt == VW'(V_ACTIVE));
  end

endmodule

// File: rtl/video_fb_gen.sv
// Scaled framebuffer video generator: timing -> registered RAM read ->
// registered palette lookup, all outputs aligned two clocks after the counters.
module video_fb_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned BPP        = 2,
  parameter int unsigned CW         = 1,
  localparam int unsigned FB_W      = H_ACTIVE >> SCALE_LOG2,
  localparam int unsigned FB_H      = V_ACTIVE >> SCALE_LOG2,
  localparam int unsigned AW        = clog2(FB_W * FB_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [CW-1:0]     red,
  output logic [CW-1:0]     grn,
  output logic [CW-1:0]     blu,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic              fr,
  input  logic [AW-1:0]     vram_waddr,
  input  logic [BPP-1:0]    vram_wdata,
  input  logic              vram_we,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_waddr,
  input  logic [3*CW-1:0]   pal_wdata
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = clog2(H_TOTAL);
  localparam int unsigned VW      = clog2(V_TOTAL);
  localparam int unsigned FB_N    = FB_W * FB_H;
  localparam int unsigned IW      = (FB_N > 1) ? $clog2(FB_N) : 1;
  localparam int unsigned PAL_N   = 1 << BPP;
  localparam int unsigned SW      = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'((1 << SCALE_LOG2) - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, hsync, vsync, vblank_start;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .active       (active),
    .hsync        (hsync),
    .vsync        (vsync),
    .vblank_start (vblank_start)
  );

  // Address generation tracks the counters: sub_x/sub_y count screen pixels
  // inside one framebuffer pixel, so no multiply is needed for the row base.
  logic [SW-1:0] sub_x, sub_y;
  logic [AW-1:0] fb_x, row_base;
  logic [IW-1:0] raddr;
  logic          line_end;

  always_comb begin
    line_end = (hcnt == HW'(H_TOTAL - 1));
    raddr    = active ? IW'(row_base + fb_x) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x    <= '0;
      sub_y    <= '0;
      fb_x     <= '0;
      row_base <= '0;
    end else if (line_end) begin
      sub_x <= '0;
      fb_x  <= '0;
      if (vcnt == VW'(V_TOTAL - 1)) begin
        sub_y    <= '0;
        row_base <= '0;
      end else if (vcnt < VW'(V_ACTIVE)) begin
        sub_y <= (sub_y == SUB_LAST) ? '0 : sub_y + 1'b1;
        if (sub_y == SUB_LAST) row_base <= row_base + AW'(FB_W);
      end
    end else if (hcnt < HW'(H_ACTIVE)) begin
      sub_x <= (sub_x == SUB_LAST) ? '0 : sub_x + 1'b1;
      if (sub_x == SUB_LAST) fb_x <= fb_x + 1'b1;
    end
  end

  // Framebuffer: one write port, registered read with read-before-write.
  logic [BPP-1:0] fb_mem [FB_N];
  logic [BPP-1:0] pix_q;

  always_ff @(posedge clk) begin
    if (vram_we && (vram_waddr < AW'(FB_N))) fb_mem[vram_waddr[IW-1:0]] <= vram_wdata;
    pix_q <= fb_mem[raddr];
  end

  logic de1, hs1, vs1, fr1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      fr1 <= 1'b0;
    end else begin
      de1 <= active;
      hs1 <= hsync;
      vs1 <= vsync;
      fr1 <= vblank_start;
    end
  end

  logic [3*CW-1:0] pal [PAL_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= (i == 0) ? '0 : '1;
    end else if (pal_we) begin
      pal[pal_waddr] <= pal_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {red, grn, blu} <= '0;
      hs              <= ~HS_POL;
      vs              <= ~VS_POL;
      de              <= 1'b0;
      fr              <= 1'b0;
    end else begin
      {red, grn, blu} <= de1 ? pal[pix_q] : '0;
      hs              <= hs1 ? HS_POL : ~HS_POL;
      vs              <= vs1 ? VS_POL : ~VS_POL;
      de              <= de1;
      fr              <= fr1;
    end
  end

endmodule

// File: tb/tb_video_fb_gen.sv
// Scoreboard bench for video_fb_gen on a 14x7 raster with a 4x2 framebuffer.
module tb_video_fb_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       red, grn, blu, hs, vs, de, fr;
  logic [3:0] vram_waddr;
  logic [1:0] vram_wdata;
  logic       vram_we;
  logic       pal_we;
  logic [1:0] pal_waddr;
  logic [2:0] pal_wdata;

  always #5 clk = ~clk;

  video_fb_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .SCALE_LOG2 (1), .BPP (2), .CW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .red        (red),
    .grn        (grn),
    .blu        (blu),
    .hs         (hs),
    .vs         (vs),
    .de         (de),
    .fr         (fr),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .pal_we     (pal_we),
    .pal_waddr  (pal_waddr),
    .pal_wdata  (pal_wdata)
  );

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fr;
    logic [1:0] pix;
  } item_t;

  localparam logic [6:0] RST_OUT = 7'b0001100;  // {r,g,b,hs,vs,de,fr}

  item_t      q[$];
  logic [1:0] fb_m [8];
  logic [2:0] pal_m [4];
  int         hc, vc, n_chk, n_pass;
  logic [6:0] exp_o, got;

  task automatic pal_reset();
    pal_m[0] = 3'b000;
    for (int i = 1; i < 4; i++) pal_m[i] = 3'b111;
  endtask

  // One clock: pop the lookup due now, push the item for the current raster
  // position, apply writes to the model, then compare the DUT outputs.
  task automatic tick();
    item_t      it;
    logic [2:0] rgb;
    @(posedge clk);
    exp_o = RST_OUT;
    if (!rst_n) begin
      q.delete();
      hc = 0;
      vc = 0;
      pal_reset();
    end else begin
      if (q.size() > 0) begin
        it    = q.pop_front();
        rgb   = it.de ? pal_m[it.pix] : 3'b000;
        exp_o = {rgb, ~it.hs, ~it.vs, it.de, it.fr};
      end
      it.de  = (hc < 8) && (vc < 4);
      it.hs  = (hc >= 10) && (hc < 12);
      it.vs  = (vc == 5);
      it.fr  = (hc == 0) && (vc == 4);
      it.pix = it.de ? fb_m[(vc / 2) * 4 + hc / 2] : 2'b00;
      q.push_back(it);
      if (pal_we) pal_m[pal_waddr] = pal_wdata;
      hc++;
      if (hc == 14) begin
        hc = 0;
        vc = (vc == 6) ? 0 : vc + 1;
      end
    end
    if (vram_we && (vram_waddr < 4'd8)) fb_m[vram_waddr[2:0]] = vram_wdata;
    #1;
    got = {red, grn, blu, hs, vs, de, fr};
    n_chk++;
    if (got !== exp_o) $display("FAIL scoreboard t=%0t got=%b exp=%b", $time, got, exp_o);
    else n_pass++;
  endtask

  task automatic release_and_check_first_de(input string name);
    int first;
    #4 rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (de && first == 0) first = i;
    end
    n_chk++;
    if (first !== 2) $display("FAIL %s first_de_clock got=%0d exp=2", name, first);
    else n_pass++;
  endtask

  task automatic count_syncs(input string name);
    int hs_low, vs_low;
    hs_low = 0;
    vs_low = 0;
    for (int i = 0; i < 98; i++) begin
      tick();
      if (!got[3]) hs_low++;
      if (!got[2]) vs_low++;
    end
    n_chk++;
    if (hs_low !== 14) $display("FAIL %s hs_low got=%0d exp=14", name, hs_low);
    else n_pass++;
    n_chk++;
    if (vs_low !== 14) $display("FAIL %s vs_low got=%0d exp=14", name, vs_low);
    else n_pass++;
  endtask

  task automatic test_reset();
    tick();
    n_chk++;
    if (got !== RST_OUT) $display("FAIL reset_values got=%b exp=%b", got, RST_OUT);
    else n_pass++;
    // Framebuffer is not reset, so load known contents while held in reset.
    for (int a = 0; a < 8; a++) begin
      vram_we    = 1'b1;
      vram_waddr = 4'(a);
      vram_wdata = (a == 5) ? 2'd3 : 2'd1;
      tick();
    end
    vram_we = 1'b0;
  endtask

  task automatic test_timing();
    release_and_check_first_de("timing");
    count_syncs("timing");
  endtask

  task automatic test_pixels();
    int n_red, n_white;
    pal_we    = 1'b1;
    pal_waddr = 2'd3;
    pal_wdata = 3'b100;
    tick();
    pal_we  = 1'b0;
    n_red   = 0;
    n_white = 0;
    for (int i = 0; i < 98; i++) begin
      tick();
      if (got[1] && got[6:4] == 3'b100) n_red++;
      if (got[1] && got[6:4] == 3'b111) n_white++;
    end
    n_chk++;
    if (n_red !== 4) $display("FAIL pixels red_count got=%0d exp=4", n_red);
    else n_pass++;
    n_chk++;
    if (n_white !== 28) $display("FAIL pixels white_count got=%0d exp=28", n_white);
    else n_pass++;
  endtask

  task automatic test_oob_write();
    int n_black, n_x;
    vram_we    = 1'b1;
    vram_waddr = 4'd8;
    vram_wdata = 2'd0;
    tick();
    vram_waddr = 4'd15;
    vram_wdata = 2'd2;
    tick();
    vram_we = 1'b0;
    n_black = 0;
    n_x     = 0;
    for (int i = 0; i < 98; i++) begin
      tick();
      if (got[1] && got[6:4] == 3'b000) n_black++;
      if ($isunknown(got)) n_x++;
    end
    n_chk++;
    if (n_black !== 0 || n_x !== 0)
      $display("FAIL oob_write black=%0d unknown=%0d exp=0/0", n_black, n_x);
    else n_pass++;
  endtask

  task automatic test_palette_race();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (q.size() == 1 && q[0].de && q[0].pix == 2'd1 && hc < 8 && vc < 4 &&
          fb_m[(vc / 2) * 4 + hc / 2] == 2'd1) found = 1'b1;
      else tick();
    end
    n_chk++;
    if (!found) begin
      $display("FAIL palette_race no_slot got=0 exp=1");
      return;
    end
    n_pass++;
    pal_we    = 1'b1;
    pal_waddr = 2'd1;
    pal_wdata = 3'b010;
    tick();
    pal_we = 1'b0;
    n_chk++;
    if (got[6:4] !== 3'b111) $display("FAIL palette_race old_colour got=%b exp=111", got[6:4]);
    else n_pass++;
    tick();
    n_chk++;
    if (got[6:4] !== 3'b010) $display("FAIL palette_race new_colour got=%b exp=010", got[6:4]);
    else n_pass++;
  endtask

  task automatic test_same_addr();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (hc == 0 && vc == 0) found = 1'b1;
      else tick();
    end
    n_chk++;
    if (!found) begin
      $display("FAIL same_addr no_slot got=0 exp=1");
      return;
    end
    n_pass++;
    vram_we    = 1'b1;  // pixel (0,0) is read in this same cycle
    vram_waddr = 4'd0;
    vram_wdata = 2'd3;
    tick();
    vram_we = 1'b0;
    tick();
    n_chk++;
    if (got[6:4] !== 3'b010) $display("FAIL same_addr old_data got=%b exp=010", got[6:4]);
    else n_pass++;
    tick();
    n_chk++;
    if (got[6:4] !== 3'b100) $display("FAIL same_addr new_data got=%b exp=100", got[6:4]);
    else n_pass++;
  endtask

  task automatic test_frame_pulse();
    int n_fr;
    int at [3];
    n_fr = 0;
    for (int i = 0; i < 294; i++) begin
      tick();
      if (got[0]) begin
        if (n_fr < 3) at[n_fr] = i;
        n_fr++;
      end
    end
    n_chk++;
    if (n_fr !== 3) $display("FAIL frame_pulse count got=%0d exp=3", n_fr);
    else n_pass++;
    n_chk++;
    if (n_fr == 3 && (at[1] - at[0] != 98 || at[2] - at[1] != 98))
      $display("FAIL frame_pulse spacing got=%0d,%0d exp=98,98", at[1] - at[0], at[2] - at[1]);
    else if (n_fr == 3) n_pass++;
    else $display("FAIL frame_pulse spacing got=unmeasured exp=98,98");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 98; i++) begin
      vram_we    = 1'b1;
      vram_waddr = 4'($urandom_range(0, 7));
      vram_wdata = 2'($urandom_range(0, 3));
      pal_we     = 1'($urandom_range(0, 1));
      pal_waddr  = 2'($urandom_range(0, 3));
      pal_wdata  = 3'($urandom_range(0, 7));
      tick();
    end
    vram_we = 1'b0;
    pal_we  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (hc == 5 && vc == 1 && got[1]) found = 1'b1;
      else tick();
    end
    #2 rst_n = 1'b0;
    #1 got = {red, grn, blu, hs, vs, de, fr};
    n_chk++;
    if (!found || got !== RST_OUT)
      $display("FAIL mid_reset immediate got=%b exp=%b found=%0d", got, RST_OUT, found);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    release_and_check_first_de("mid_reset");
    count_syncs("mid_reset");
  endtask

  initial begin
    rst_n      = 1'b0;
    vram_we    = 1'b0;
    vram_waddr = '0;
    vram_wdata = '0;
    pal_we     = 1'b0;
    pal_waddr  = '0;
    pal_wdata  = '0;
    n_chk      = 0;
    n_pass     = 0;
    hc         = 0;
    vc         = 0;
    got        = '0;
    for (int i = 0; i < 8; i++) fb_m[i] = 2'd0;
    pal_reset();

    test_reset();
    test_timing();
    test_pixels();
    test_oob_write();
    test_palette_race();
    test_same_addr();
    test_frame_pulse();
    test_back_to_back();
    test_mid_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_fb_gen.md
VIDEO_FB_GEN -- requirements
Module: video_fb_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0/0, sync active level (0 = active-low).
REQ-006 SHALL have parameter SCALE_LOG2, default 4, meaning each framebuffer pixel covers a 2^SCALE_LOG2 square (default gives 40x30).
REQ-007 SHALL have parameter BPP, default 2, range 1..4, bits per framebuffer pixel.
REQ-008 SHALL have parameter CW, default 1, bits per colour channel.
REQ-009 SHALL derive FB_W = H_ACTIVE>>SCALE_LOG2, FB_H = V_ACTIVE>>SCALE_LOG2, AW = clog2(FB_W*FB_H).
REQ-010 Ports: clk  in  1  pixel clock, sole clock.
REQ-011 rst_n  in  1  asynchronous active-low reset.
REQ-012 red, grn, blu  out  CW each  pixel colour.
REQ-013 hs, vs  out  1  syncs at HS_POL/VS_POL level.
REQ-014 de  out  1  active video.
REQ-015 fr  out  1  one-cycle start-of-vblank pulse.
REQ-016 vram_waddr in AW; vram_wdata in BPP; vram_we in 1: framebuffer write port, linear row-major address.
REQ-017 pal_we in 1; pal_waddr in BPP; pal_wdata in 3*CW {r,g,b}: palette write port.

Function
REQ-018 Free-running hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1; vcnt advances when hcnt wraps; both wrap to 0 together at end of frame.
REQ-019 Active when hcnt<H_ACTIVE and vcnt<V_ACTIVE; sync asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), vcnt analogously.
REQ-020 Pipeline: stage 1 registered framebuffer read, stage 2 registered palette lookup; all outputs (rgb, hs, vs, de, fr) delayed exactly 2 clocks from counter state, mutually aligned.
REQ-021 Read address from incremental row-base plus column counters, no multiplier; row base advances by FB_W after every 2^SCALE_LOG2 active lines, resets to 0 at vcnt wrap.
REQ-022 rgb SHALL be 0 whenever de is 0.
REQ-023 fr high one cycle when output timing enters hcnt=0, vcnt=V_ACTIVE.
REQ-024 vram_we with vram_waddr >= FB_W*FB_H SHALL be ignored.
REQ-025 Same-cycle write and read to one framebuffer address returns old data; new data visible from next read.
REQ-026 Palette write takes effect on the next clock; a pixel looked up in the write cycle uses the old entry.
REQ-027 Writes accepted every cycle, any timing phase, no back-pressure.

Reset
REQ-028 While rst_n low: counters, row base and pipeline cleared; de=0, fr=0, rgb=0, hs=!HS_POL... i.e. inactive level, vs inactive level.
REQ-029 Palette resets to entry 0 = all zeros, all other entries = all ones; framebuffer contents not reset.
REQ-030 Reset assertion mid-frame takes effect immediately (async); after release first active pixel appears 2 clocks after hcnt=0,vcnt=0.

Structure
REQ-031 Shared package video_pkg holds 640x480@60 timing constants and the clog2 helper.
REQ-032 Counter/sync logic SHALL be sub-module video_timing (outputs hcnt, vcnt, active, hsync, vsync, vblank_start, all unregistered-stage-0).
REQ-033 Framebuffer SHALL infer block RAM (one write port, one registered read port).

Verification (small timing: H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1,SCALE_LOG2=1,BPP=2,CW=1)
REQ-034 Reset release -> de first high at clock 2 after release; hs low for exactly 2 of every 14 clocks; vs low exactly 1 line (14 clocks) of every 7 lines.
REQ-035 Write addr 5 = 2'b11, palette[3]=3'b100 -> pixels x=2..3, y=2..3 output red=1,grn=0,blu=0; all other pixels white (default palette, data 0 -> black only if written 0).
REQ-036 Write addr 8 (>= 8 entries) -> no framebuffer change, no X on outputs.
REQ-037 Palette write during active pixel of that index -> that pixel old colour, next pixel new colour.
REQ-038 fr counted over 3 frames -> exactly 3 single-cycle pulses, 98 clocks apart.
REQ-039 rst_n low mid-line -> outputs at reset values same cycle; sync resumes per REQ-030.
